// File: rtl/gray_count_receiver.sv
// Destination-domain receiver for a Gray-coded counter: synchronises it into clk_out,
// converts it to binary, validates each transition and accumulates legal +1 steps.
module gray_count_receiver #(
  parameter int GW          = 2,
  parameter int SYNC_STAGES = 2,
  parameter int ACC_W       = 16
) (
  input  logic             clk_out,
  input  logic             rst,
  input  logic [GW-1:0]    gray_i,
  input  logic             clr_i,
  output logic [GW-1:0]    bin_o,
  output logic             step_o,
  output logic [ACC_W-1:0] total_o,
  output logic             lock_o,
  output logic             err_o,
  output logic             ovf_o
);

  typedef enum logic {INIT, TRACK} state_e;

  state_e             state_q, state_d;
  logic [GW-1:0]      sync_q [SYNC_STAGES];
  logic [GW-1:0]      sync_d [SYNC_STAGES];
  logic [GW-1:0]      p_q, p_d;
  logic [GW-1:0]      bin_q, bin_d;
  logic [ACC_W-1:0]   total_q, total_d;
  logic               step_q, step_d;
  logic               lock_q, lock_d;
  logic               err_q, err_d;
  logic               ovf_q, ovf_d;

  logic [GW-1:0]      s;
  logic [GW-1:0]      diff;
  logic               one_bit;
  logic               fwd;
  logic               legal;

  function automatic logic [GW-1:0] gray2bin(input logic [GW-1:0] g);
    logic [GW-1:0] b;
    b[GW-1] = g[GW-1];
    for (int unsigned i = 1; i < GW; i++) begin
      b[GW-1-i] = b[GW-i] ^ g[GW-1-i];
    end
    return b;
  endfunction

  always_comb begin
    sync_d[0] = gray_i;
    for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  assign s       = sync_q[SYNC_STAGES-1];
  assign diff    = s ^ p_q;
  // exactly one bit differs: non-zero and a power of two
  assign one_bit = (diff != '0) && ((diff & (diff - GW'(1))) == '0);
  assign fwd     = gray2bin(s) == (gray2bin(p_q) + GW'(1));

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    bin_d   = bin_q;
    total_d = total_q;
    step_d  = 1'b0;
    lock_d  = lock_q;
    err_d   = err_q;
    ovf_d   = ovf_q;
    legal   = 1'b0;

    if (clr_i) begin
      total_d = '0;
      err_d   = 1'b0;
      ovf_d   = 1'b0;
    end

    case (state_q)
      INIT: begin
        p_d     = s;
        bin_d   = gray2bin(s);
        lock_d  = 1'b1;
        state_d = TRACK;
      end
      TRACK: begin
        if (diff != '0) begin
          p_d   = s;
          bin_d = gray2bin(s);
          if (one_bit && fwd) legal = 1'b1;
          else                err_d = 1'b1;
        end
      end
      default: state_d = INIT;
    endcase

    // a step coinciding with clear is counted into the freshly cleared total
    if (legal) begin
      step_d = 1'b1;
      if (clr_i)                total_d = {{(ACC_W-1){1'b0}}, 1'b1};
      else if (total_q == '1)   ovf_d   = 1'b1;
      else                      total_d = total_q + ACC_W'(1);
    end
  end

  always_ff @(posedge clk_out or negedge rst) begin
    if (!rst) begin
      for (int unsigned k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      state_q <= INIT;
      p_q     <= '0;
      bin_q   <= '0;
      total_q <= '0;
      step_q  <= 1'b0;
      lock_q  <= 1'b0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < SYNC_STAGES; k++) sync_q[k] <= sync_d[k];
      state_q <= state_d;
      p_q     <= p_d;
      bin_q   <= bin_d;
      total_q <= total_d;
      step_q  <= step_d;
      lock_q  <= lock_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bin_o   = bin_q;
  assign step_o  = step_q;
  assign total_o = total_q;
  assign lock_o  = lock_q;
  assign err_o   = err_q;
  assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_gray_count_receiver.sv
// Scoreboard bench for gray_count_receiver: default instance plus a 3-bit-accumulator instance.
module tb_gray_count_receiver;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr, clr_s;
  logic [1:0]  gray, gray_s;

  logic [1:0]  bin, bin_s;
  logic        step, step_s, lock, lock_s, err, err_s, ovf, ovf_s;
  logic [15:0] total;
  logic [2:0]  total_s;

  always #5 clk = ~clk;

  gray_count_receiver #(.GW(2), .SYNC_STAGES(2), .ACC_W(16)) dut (
    .clk_out(clk), .rst(rst), .gray_i(gray), .clr_i(clr),
    .bin_o(bin), .step_o(step), .total_o(total), .lock_o(lock), .err_o(err), .ovf_o(ovf)
  );

  gray_count_receiver #(.GW(2), .SYNC_STAGES(2), .ACC_W(3)) dut_sat (
    .clk_out(clk), .rst(rst), .gray_i(gray_s), .clr_i(clr_s),
    .bin_o(bin_s), .step_o(step_s), .total_o(total_s), .lock_o(lock_s), .err_o(err_s), .ovf_o(ovf_s)
  );

  typedef struct {
    logic [15:0] total;
    int unsigned at_edge;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          n_cmp = 0;
  int          n_bad = 0;
  int unsigned cyc = 0;
  int unsigned sat_pulses = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every step pulse of the main instance must match the next queued expectation
  always @(negedge clk) begin
    if (rst === 1'b1 && step === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_step: got step with total %0d, expected no step (cycle %0d)", total, cyc);
      end else begin
        e = sb.pop_front();
        chk("step_total", {16'h0, total}, {16'h0, e.total});
        chk("step_latency", cyc, e.at_edge);
      end
    end
  end

  always @(negedge clk) if (step_s === 1'b1) sat_pulses++;

  task automatic drive(input logic [1:0] g, input bit legal, input logic [15:0] exp_total);
    @(posedge clk); #1;
    gray = g;
    if (legal) sb.push_back('{exp_total, cyc + 3});
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic drive_s(input logic [1:0] g);
    @(posedge clk); #1;
    gray_s = g;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic clr_pulse();
    @(posedge clk); #1; clr = 1'b1;
    @(posedge clk); #1; clr = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_bin"},   {30'h0, bin},   32'h0);
    chk({tag, "_step"},  {31'h0, step},  32'h0);
    chk({tag, "_total"}, {16'h0, total}, 32'h0);
    chk({tag, "_lock"},  {31'h0, lock},  32'h0);
    chk({tag, "_err"},   {31'h0, err},   32'h0);
    chk({tag, "_ovf"},   {31'h0, ovf},   32'h0);
    chk({tag, "_s_total"}, {29'h0, total_s}, 32'h0);
    chk({tag, "_s_flags"}, {26'h0, bin_s, step_s, lock_s, err_s, ovf_s}, 32'h0);
  endtask

  logic [1:0] sat_seq [9] = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01, 2'b11, 2'b10, 2'b00, 2'b01};

  initial begin
    rst = 1'b0; clr = 1'b0; clr_s = 1'b0; gray = '0; gray_s = '0;

    // reset held while the Gray inputs toggle
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      gray   = i[1:0];
      gray_s = i[1:0];
    end
    chk_all_zero("reset");
    gray = '0; gray_s = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    chk("lock_before_edge", {31'h0, lock}, 32'h0);
    @(posedge clk); #1;
    chk("lock_after_edge", {31'h0, lock}, 32'h1);
    chk("init_no_step", {31'h0, step}, 32'h0);
    chk("init_no_err", {31'h0, err}, 32'h0);
    repeat (2) @(posedge clk);

    // full count cycle including wrap
    drive(2'b01, 1'b1, 16'd1); chk("bin_01", {30'h0, bin}, 32'd1);
    drive(2'b11, 1'b1, 16'd2); chk("bin_11", {30'h0, bin}, 32'd2);
    drive(2'b10, 1'b1, 16'd3); chk("bin_10", {30'h0, bin}, 32'd3);
    drive(2'b00, 1'b1, 16'd4); chk("bin_00", {30'h0, bin}, 32'd0);
    @(posedge clk); #1;
    chk("count_total", {16'h0, total}, 32'd4);
    chk("count_err", {31'h0, err}, 32'h0);

    // two-bit jump then legal step
    drive(2'b11, 1'b0, 16'd0);
    chk("jump_err", {31'h0, err}, 32'h1);
    chk("jump_total", {16'h0, total}, 32'd4);
    drive(2'b10, 1'b1, 16'd5);
    chk("after_jump_total", {16'h0, total}, 32'd5);
    chk("err_sticky", {31'h0, err}, 32'h1);

    // backward step
    clr_pulse();
    chk("clr_err", {31'h0, err}, 32'h0);
    chk("clr_total", {16'h0, total}, 32'd0);
    drive(2'b00, 1'b1, 16'd1);
    drive(2'b01, 1'b1, 16'd2);
    drive(2'b00, 1'b0, 16'd0);
    chk("back_err", {31'h0, err}, 32'h1);
    chk("back_total", {16'h0, total}, 32'd2);
    chk("back_step", {31'h0, step}, 32'h0);
    clr_pulse();
    chk("clr2_err", {31'h0, err}, 32'h0);
    chk("clr2_total", {16'h0, total}, 32'd0);

    // clear coinciding with a legal step
    drive(2'b01, 1'b1, 16'd1);
    @(posedge clk); #1;
    gray = 2'b11;
    sb.push_back('{16'd1, cyc + 3});
    repeat (2) @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    chk("clrstep_total", {16'h0, total}, 32'd1);
    chk("clrstep_step", {31'h0, step}, 32'h1);
    chk("clrstep_err", {31'h0, err}, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 32'd0);

    // saturation on the 3-bit accumulator instance
    for (int i = 0; i < 9; i++) begin
      drive_s(sat_seq[i]);
      if (i == 6) begin
        chk("sat7_total", {29'h0, total_s}, 32'd7);
        chk("sat7_ovf", {31'h0, ovf_s}, 32'h0);
      end
    end
    @(posedge clk); #1;
    chk("sat_total", {29'h0, total_s}, 32'd7);
    chk("sat_ovf", {31'h0, ovf_s}, 32'h1);
    chk("sat_pulses", sat_pulses, 32'd9);
    chk("sat_err", {31'h0, err_s}, 32'h0);

    // asynchronous reset in the middle of a cycle
    gray_s = 2'b11;
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk_all_zero("midreset");
    chk("final_sb_empty", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
